// File: rtl/wb_ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_port_arbiter_pkg
// Brief    : Shared FSM encoding and sizing helper for the RAM port arbiter
// Revision : 1.0
// ============================================================================
package wb_ram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_t;

   // Ceiling log2, never below 1 so a single-value range still gets a bit.
   function automatic int log2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_port_arbiter_if
// Brief    : Bundled master-side and slave-side Wishbone signals of the arbiter
// Revision : 1.0
// ============================================================================
interface wb_ram_port_arbiter_if #(
   parameter int M    = 4,
   parameter int Dw   = 32,
   parameter int Aw   = 10,
   parameter int CTIw = 3,
   parameter int BTEw = 2
);
   localparam int SELw = Dw / 8;

   logic [M*Dw-1:0]   m_dat_i;
   logic [M*SELw-1:0] m_sel_i;
   logic [M*Aw-1:0]   m_addr_i;
   logic [M*CTIw-1:0] m_cti_i;
   logic [M*BTEw-1:0] m_bte_i;
   logic [M-1:0]      m_stb_i;
   logic [M-1:0]      m_cyc_i;
   logic [M-1:0]      m_we_i;
   logic [Dw-1:0]     m_dat_o;
   logic [M-1:0]      m_ack_o;
   logic [M-1:0]      m_err_o;

   logic [Dw-1:0]     s_dat_o;
   logic [SELw-1:0]   s_sel_o;
   logic [Aw-1:0]     s_addr_o;
   logic [CTIw-1:0]   s_cti_o;
   logic [BTEw-1:0]   s_bte_o;
   logic              s_we_o;
   logic              s_stb_o;
   logic              s_cyc_o;
   logic [Dw-1:0]     s_dat_i;
   logic              s_ack_i;

   logic [M-1:0]      grant_o;

   // Arbiter view: slave to the masters, driver of the RAM port.
   modport slave (
      input  m_dat_i, m_sel_i, m_addr_i, m_cti_i, m_bte_i, m_stb_i, m_cyc_i, m_we_i,
      input  s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_dat_o, s_sel_o, s_addr_o, s_cti_o, s_bte_o, s_we_o, s_stb_o, s_cyc_o,
      output grant_o
   );

   // Environment view: the masters plus the RAM port they share.
   modport master (
      output m_dat_i, m_sel_i, m_addr_i, m_cti_i, m_bte_i, m_stb_i, m_cyc_i, m_we_i,
      output s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_dat_o, s_sel_o, s_addr_o, s_cti_o, s_bte_o, s_we_o, s_stb_o, s_cyc_o,
      input  grant_o
   );

endinterface

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Brief    : Combinational round-robin pick starting after the last winner
// Revision : 1.0
// ============================================================================
module wb_rr_arbiter #(
   parameter int M  = 4,
   parameter int LW = 2
) (
   input  logic [M-1:0]  i_req,
   input  logic [LW-1:0] i_last,
   output logic [M-1:0]  o_grant,
   output logic [LW-1:0] o_idx
);

   int   w_idx;
   logic w_found;

   // Offsets run 1..M so the last winner is considered only after everyone else.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 1; k <= M; k++) begin
         w_idx = (int'(i_last) + k) % M;
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_idx          = LW'(w_idx);
            w_found        = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_port_arbiter
// Brief    : Round-robin Wishbone arbiter with stall watchdog for one RAM port
// Revision : 1.0
// ============================================================================
module wb_ram_port_arbiter
   import wb_ram_port_arbiter_pkg::*;
#(
   parameter int M       = 4,
   parameter int Dw      = 32,
   parameter int Aw      = 10,
   parameter int CTIw    = 3,
   parameter int BTEw    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   wb_ram_port_arbiter_if.slave  bus
);

   localparam int c_selw = Dw / 8;
   localparam int c_lw   = log2(M);
   localparam int c_wdw  = log2(TIMEOUT + 1);
   localparam logic [c_lw-1:0]  c_last_rst = c_lw'(M - 1);
   localparam logic [c_wdw-1:0] c_wd_max   = c_wdw'(TIMEOUT);

   arb_state_t        r_state, w_state_nxt;
   logic [M-1:0]      r_grant, w_grant_nxt;
   logic [c_lw-1:0]   r_last,  w_last_nxt;
   logic [c_wdw-1:0]  r_wd,    w_wd_nxt;

   logic [M-1:0]      w_rr_grant;
   logic [c_lw-1:0]   w_rr_idx;
   logic              w_busy;
   logic              w_gcyc;
   logic              w_gstb;
   logic              w_stall;
   logic              w_timeout;

   wb_rr_arbiter #(
      .M  (M),
      .LW (c_lw)
   ) u_rr (
      .i_req   (bus.m_cyc_i),
      .i_last  (r_last),
      .o_grant (w_rr_grant),
      .o_idx   (w_rr_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_last  <= c_last_rst;
         r_wd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_wd    <= w_wd_nxt;
      end
   end

   // r_last doubles as the index of the current owner while a grant is held.
   always_comb begin
      w_busy        = (r_state == ST_BUSY);
      w_gcyc        = bus.m_cyc_i[r_last];
      w_gstb        = bus.m_stb_i[r_last];

      bus.s_dat_o   = '0;
      bus.s_sel_o   = '0;
      bus.s_addr_o  = '0;
      bus.s_cti_o   = '0;
      bus.s_bte_o   = '0;
      bus.s_we_o    = 1'b0;
      if (r_grant != '0) begin
         bus.s_dat_o  = bus.m_dat_i [r_last*Dw     +: Dw];
         bus.s_sel_o  = bus.m_sel_i [r_last*c_selw +: c_selw];
         bus.s_addr_o = bus.m_addr_i[r_last*Aw     +: Aw];
         bus.s_cti_o  = bus.m_cti_i [r_last*CTIw   +: CTIw];
         bus.s_bte_o  = bus.m_bte_i [r_last*BTEw   +: BTEw];
         bus.s_we_o   = bus.m_we_i[r_last];
      end
      bus.s_stb_o   = w_busy & w_gstb;
      bus.s_cyc_o   = w_busy;
      bus.m_dat_o   = bus.s_dat_i;
      bus.grant_o   = r_grant;
   end

   // The watchdog fires on the cycle the counter holds TIMEOUT, i.e. after
   // TIMEOUT consecutive stalled beats; that cycle reports err instead of ack.
   always_comb begin
      w_stall   = w_busy & bus.s_stb_o & ~bus.s_ack_i;
      w_timeout = (TIMEOUT > 0) && w_busy && (r_wd == c_wd_max);
      w_wd_nxt  = '0;
      if ((TIMEOUT > 0) && w_stall && !w_timeout) begin
         w_wd_nxt = r_wd + 1'b1;
      end
   end

   // Responses are gated by reset so an ack landing in the reset cycle is dropped.
   always_comb begin
      bus.m_ack_o = '0;
      bus.m_err_o = '0;
      if (!reset) begin
         if (w_timeout) begin
            bus.m_err_o = r_grant;
         end else if (w_busy && bus.s_ack_i) begin
            bus.m_ack_o = r_grant;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      case (r_state)
         ST_IDLE: begin
            if (|bus.m_cyc_i) begin
               w_state_nxt = ST_BUSY;
               w_grant_nxt = w_rr_grant;
               w_last_nxt  = w_rr_idx;
            end
         end
         ST_BUSY: begin
            if (w_timeout) begin
               w_state_nxt = ST_ABORT;
            end else if (!w_gcyc) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
            end
         end
         ST_ABORT: begin
            if (!w_gcyc) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ram_port_arbiter
// Brief    : Scoreboard bench: four masters, a zero-wait RAM model, watchdog
// Revision : 1.0
// ============================================================================
module tb_wb_ram_port_arbiter;

   localparam int M  = 4;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int TO = 16;

   typedef struct packed {
      logic          we;
      logic          err;
      logic [2:0]    cti;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } sb_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   wb_ram_port_arbiter_if #(.M(M), .Dw(DW), .Aw(AW), .CTIw(3), .BTEw(2)) bus ();

   wb_ram_port_arbiter #(
      .M(M), .Dw(DW), .Aw(AW), .CTIw(3), .BTEw(2), .TIMEOUT(TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic          mcyc [M];
   logic          mstb [M];
   logic          mwe  [M];
   logic [AW-1:0] madr [M];
   logic [DW-1:0] mdat [M];
   logic [2:0]    mcti [M];
   int            beat [M];
   int            ackcnt [M];

   always_comb begin
      for (int i = 0; i < M; i++) begin
         bus.m_cyc_i[i]             = mcyc[i];
         bus.m_stb_i[i]             = mstb[i];
         bus.m_we_i[i]              = mwe[i];
         bus.m_addr_i[i*AW +: AW]   = madr[i];
         bus.m_dat_i[i*DW +: DW]    = mdat[i];
         bus.m_cti_i[i*3 +: 3]      = mcti[i];
         bus.m_bte_i[i*2 +: 2]      = 2'b00;
         bus.m_sel_i[i*4 +: 4]      = 4'hF;
      end
   end

   // Zero-wait RAM slave: combinational ack, write on the acked edge.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          slave_en;
   assign bus.s_ack_i = slave_en & bus.s_cyc_o & bus.s_stb_o;
   assign bus.s_dat_i = mem[bus.s_addr_o];
   always @(posedge clk) begin
      if (bus.s_ack_i && bus.s_we_o) begin
         for (int b = 0; b < 4; b++)
            if (bus.s_sel_o[b]) mem[bus.s_addr_o][b*8 +: 8] <= bus.s_dat_o[b*8 +: 8];
      end
   end

   sb_t          sbq [M][$];
   int           gq [$];
   int           checks = 0;
   int           errors = 0;
   logic [M-1:0] prev_grant = '0;

   // Response/grant monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic [M-1:0] hit;
      int           idx;
      int           g;
      sb_t          e;
      hit = bus.m_ack_o | bus.m_err_o;
      if (hit != '0) begin
         checks++;
         idx = 0;
         for (int i = 0; i < M; i++) if (hit[i]) idx = i;
         if (bus.m_ack_o[idx]) ackcnt[idx]++;
         if (!$onehot(hit) || ((bus.m_ack_o & bus.m_err_o) != '0)) begin
            errors++;
            $display("FAIL resp_onehot: ack=%b err=%b, required one master with ack xor err",
                     bus.m_ack_o, bus.m_err_o);
         end else if (sbq[idx].size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: master %0d ack=%b err=%b, required no response",
                     idx, bus.m_ack_o, bus.m_err_o);
         end else begin
            e = sbq[idx].pop_front();
            if (bus.m_err_o[idx] !== e.err || bus.s_addr_o !== e.adr || bus.s_we_o !== e.we ||
                bus.s_cti_o !== e.cti ||
                (!e.err && ((e.we ? bus.s_dat_o : bus.m_dat_o) !== e.dat))) begin
               errors++;
               $display("FAIL resp_m%0d: err=%b adr=%h we=%b cti=%b wdat=%h rdat=%h, required err=%b adr=%h we=%b cti=%b dat=%h",
                        idx, bus.m_err_o[idx], bus.s_addr_o, bus.s_we_o, bus.s_cti_o, bus.s_dat_o,
                        bus.m_dat_o, e.err, e.adr, e.we, e.cti, e.dat);
            end
         end
      end
      if (bus.grant_o != '0 && bus.grant_o != prev_grant) begin
         checks++;
         if (gq.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: grant=%b, required none", bus.grant_o);
         end else begin
            g = gq.pop_front();
            if (bus.grant_o != (M'(1) << g) || prev_grant != '0 || !bus.s_cyc_o) begin
               errors++;
               $display("FAIL grant_order: grant=%b prev=%b cyc=%b, required grant=%b prev=0 cyc=1",
                        bus.grant_o, prev_grant, bus.s_cyc_o, M'(1) << g);
            end
         end
      end
      prev_grant = bus.grant_o;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic wait_resp(input int m, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.m_ack_o[m] || bus.m_err_o[m]) begin
            ok = 1'b1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL resp_timeout_m%0d: no response in 200 cycles, required ack", m);
   endtask

   task automatic xfer(input int m, input bit we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input int nbeats);
      bit ok;
      @(posedge clk); #1;
      mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = we;
      for (int k = 0; k < nbeats; k++) begin
         beat[m] = k;
         madr[m] = adr + AW'(k);
         mdat[m] = we ? dat + DW'(k) : '0;
         mcti[m] = (nbeats == 1) ? 3'b000 : (k == nbeats - 1) ? 3'b111 : 3'b010;
         sbq[m].push_back('{we: we, err: 1'b0, cti: mcti[m], adr: adr + AW'(k), dat: dat + DW'(k)});
         wait_resp(m, ok);
         @(posedge clk); #1;
         if (!ok) break;
      end
      mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0; mcti[m] = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bit ok;
      int n;
      bit seen;
      int a1;
      for (int i = 0; i < M; i++) begin
         mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0; madr[i] = '0; mdat[i] = '0; mcti[i] = '0;
         beat[i] = -1; ackcnt[i] = 0;
      end
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      slave_en = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", bus.grant_o, 0);
      chk("rst_s_cyc", bus.s_cyc_o, 0);
      chk("rst_s_stb", bus.s_stb_o, 0);
      chk("rst_s_addr", bus.s_addr_o, 0);
      chk("rst_s_dat", bus.s_dat_o, 0);
      chk("rst_ack_err", {bus.m_ack_o, bus.m_err_o}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Master 2 alone: write then read back, grant one cycle after request
      gq.push_back(2); gq.push_back(2);
      fork
         xfer(2, 1'b1, 10'h010, 32'hDEADBEEF, 1);
         begin
            @(posedge clk); #1;
            @(negedge clk); chk("lat_cyc_req_cycle", bus.s_cyc_o, 0);
            @(negedge clk); chk("lat_cyc_next", bus.s_cyc_o, 1);
            chk("lat_grant_m2", bus.grant_o, 4'b0100);
         end
      join
      xfer(2, 1'b0, 10'h010, 32'hDEADBEEF, 1);

      // All four after a fresh reset: served 0,1,2,3 with idle gaps
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3);
      fork
         xfer(0, 1'b1, 10'h020, 32'h11111111, 1);
         xfer(1, 1'b1, 10'h021, 32'h22222222, 1);
         xfer(2, 1'b1, 10'h022, 32'h33333333, 1);
         xfer(3, 1'b1, 10'h023, 32'h44444444, 1);
      join
      repeat (3) @(posedge clk);

      // 8-beat burst on master 1; master 0 arrives at beat 2 and must wait
      a1 = ackcnt[1];
      gq.push_back(1); gq.push_back(0);
      fork
         xfer(1, 1'b1, 10'h100, 32'hA0000000, 8);
         begin
            for (int c = 0; c < 100 && beat[1] != 2; c++) @(negedge clk);
            xfer(0, 1'b0, 10'h010, 32'hDEADBEEF, 1);
         end
      join
      chk("burst_acks_m1", ackcnt[1] - a1, 8);
      repeat (3) @(posedge clk);

      // Watchdog: slave silent, master 3 aborted, then master 0 served
      slave_en = 1'b0;
      gq.push_back(3); gq.push_back(0);
      fork
         begin
            n = 0; seen = 1'b0;
            @(posedge clk); #1;
            mcyc[3] = 1; mstb[3] = 1; mwe[3] = 0; madr[3] = 10'h020; mcti[3] = 3'b000;
            sbq[3].push_back('{we: 1'b0, err: 1'b1, cti: 3'b000, adr: 10'h020, dat: '0});
            for (int c = 0; c < 100; c++) begin
               @(negedge clk);
               if (bus.m_err_o[3]) begin seen = 1'b1; break; end
               if (bus.s_cyc_o) n++;
            end
            chk("wd_err_seen", seen, 1);
            chk("wd_stall_cycles", n, 16);
            slave_en = 1'b1;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               chk("abort_s_cyc", bus.s_cyc_o, 0);
               chk("abort_grant", bus.grant_o, 4'b1000);
            end
            @(posedge clk); #1;
            mcyc[3] = 0; mstb[3] = 0;
         end
         begin
            repeat (5) @(posedge clk);
            xfer(0, 1'b0, 10'h020, 32'h11111111, 1);
         end
      join
      repeat (3) @(posedge clk);

      // Reset during beat 4 of a read burst on master 2
      gq.push_back(2);
      @(posedge clk); #1;
      mcyc[2] = 1; mstb[2] = 1; mwe[2] = 0; mcti[2] = 3'b010;
      for (int k = 0; k < 4; k++) begin
         madr[2] = 10'h100 + AW'(k);
         sbq[2].push_back('{we: 1'b0, err: 1'b0, cti: 3'b010, adr: 10'h100 + AW'(k),
                            dat: 32'hA0000000 + DW'(k)});
         wait_resp(2, ok);
         @(posedge clk); #1;
      end
      madr[2] = 10'h104;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_ack_blocked", bus.m_ack_o, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      mcyc[2] = 0; mstb[2] = 0; mcti[2] = 3'b000;
      mcyc[3] = 1; mstb[3] = 1; mwe[3] = 0; madr[3] = 10'h023;
      mcyc[0] = 1; mstb[0] = 1; mwe[0] = 0; madr[0] = 10'h021; mcti[0] = 3'b000;
      sbq[0].push_back('{we: 1'b0, err: 1'b0, cti: 3'b000, adr: 10'h021, dat: 32'h22222222});
      gq.push_back(0);
      @(negedge clk);
      chk("rst_mid_s_cyc", bus.s_cyc_o, 0);
      chk("rst_mid_grant", bus.grant_o, 0);
      @(negedge clk);
      chk("rst_rr_restart_m0", bus.grant_o, 4'b0001);
      @(posedge clk); #1;
      mcyc[0] = 0; mstb[0] = 0; mcyc[3] = 0; mstb[3] = 0;
      repeat (4) @(posedge clk);

      for (int i = 0; i < M; i++) chk($sformatf("sb_drain_m%0d", i), sbq[i].size(), 0);
      chk("grant_drain", gq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
